// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single-cycle ALU.
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP waits for the taker.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             gnt_q;
    logic             gnt_sel;
    logic             accept;
    logic             rsp_done;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic [CNT_W-1:0] op_count_q;

    function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        // On a tie the requester that did not win last time is favoured.
        gnt_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = rst && (state_q == IDLE) && req0_valid && !gnt_sel;
        req1_ready = rst && (state_q == IDLE) && req1_valid && gnt_sel;
        accept     = req0_ready || req1_ready;
        rsp0_valid = rst && (state_q == RESP) && !gnt_q;
        rsp1_valid = rst && (state_q == RESP) && gnt_q;
        rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
        rsp_err    = err_q && (rsp0_valid || rsp1_valid);
        rsp_result = result_q;
        busy       = rst && (state_q != IDLE);
        op_count   = op_count_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = EXEC;
            EXEC:                  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_count_q   <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == EXEC) begin
                result_q <= alu_eval(a_q, b_q, op_q);
                err_q    <= op_q[2] && (op_q[1:0] != 2'b00);
            end
            if (rsp_done) begin
                last_grant_q <= gnt_q;
                op_count_q   <= sat_inc(op_count_q);
            end
        end
    end

    // Operand capture needs no reset: it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            gnt_q <= gnt_sel;
            a_q   <= gnt_sel ? req1_a  : req0_a;
            b_q   <= gnt_sel ? req1_b  : req0_b;
            op_q  <= gnt_sel ? req1_op : req0_op;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_err, busy;
    logic [2:0]  op_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic       lastg_m;
    int         count_m;

    alu_arbiter #(.WIDTH(32), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [2:0] op);
        longint unsigned full;
        case (op)
            3'd0: full = longint'(a) + longint'(b);
            3'd1: full = longint'(a) + 64'h1_0000_0000 - longint'(b);
            3'd2: full = longint'(a & b);
            3'd3: full = longint'(a | b);
            3'd4: full = 64'hFFFF_FFFF - longint'(a);
            default: full = 0;
        endcase
        return full[31:0];
    endfunction

    function automatic int model_sat(input int c);
        return (c >= 7) ? 7 : c + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
    endtask

    // Runs one op on port p with the response taken immediately; returns what was observed.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output logic rdy, output logic early_v, output logic rv,
                         output logic [31:0] res, output logic er);
        if (p == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = 1; end
        else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = 1; end
        #1;
        rdy = (p == 0) ? req0_ready : req1_ready;
        step();
        req0_valid = 0; req1_valid = 0;
        #1;
        early_v = rsp0_valid | rsp1_valid;
        step();
        rv  = (p == 0) ? rsp0_valid : rsp1_valid;
        res = rsp_result;
        er  = rsp_err;
        step();
        rsp0_ready = 0; rsp1_ready = 0;
        lastg_m = (p != 0);
        count_m = model_sat(count_m);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        req0_valid = 1; req1_valid = 1;
        step(); step();
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 000000",
                {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy});
        end
        checks++;
        if (op_count !== 3'd0 || rsp_result !== 32'd0) begin
            errors++; $display("FAIL reset_state count %0d result %h want 0 0", op_count, rsp_result);
        end
        rst = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_first_tie got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        lastg_m = 1; count_m = 0;
    endtask

    task automatic test_single();
        logic rdy, ev, rv, er; logic [31:0] res;
        do_op(0, 32'd5, 32'd3, 3'b000, rdy, ev, rv, res, er);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", rdy); end
        checks++;
        if (ev !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", ev); end
        checks++;
        if (rv !== 1'b1 || res !== 32'd8 || er !== 1'b0) begin
            errors++; $display("FAIL single_resp got v=%b r=%0d e=%b want 1 8 0", rv, res, er);
        end
        checks++;
        if (op_count !== 3'(count_m) || busy !== 1'b0) begin
            errors++; $display("FAIL single_count got %0d busy %b want %0d 0", op_count, busy, count_m);
        end
    endtask

    task automatic test_wrap_not();
        logic rdy, ev, rv, er; logic [31:0] res;
        do_op(1, 32'd0, 32'd1, 3'b001, rdy, ev, rv, res, er);
        checks++;
        if (rv !== 1'b1 || res !== 32'hFFFF_FFFF || er !== 1'b0) begin
            errors++; $display("FAIL wrap_sub got v=%b r=%h e=%b want 1 ffffffff 0", rv, res, er);
        end
        do_op(0, 32'h0F0F_0F0F, 32'h1234_5678, 3'b100, rdy, ev, rv, res, er);
        checks++;
        if (rv !== 1'b1 || res !== 32'hF0F0_F0F0) begin
            errors++; $display("FAIL not_op got v=%b r=%h want 1 f0f0f0f0", rv, res);
        end
    endtask

    task automatic test_tie();
        logic g;
        test_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = 32'(i); req0_b = 1; req0_op = 0;
            req1_a = 32'(i); req1_b = 2; req1_op = 0;
            g = (i % 2 == 1);
            #1;
            checks++;
            if (req0_ready !== !g || req1_ready !== g) begin
                errors++; $display("FAIL tie_grant op %0d got r0=%b r1=%b want grant %0d",
                    i, req0_ready, req1_ready, g);
            end
            step(); step();
            checks++;
            if (rsp0_valid !== !g || rsp1_valid !== g || rsp_result !== 32'(i) + (g ? 32'd2 : 32'd1)) begin
                errors++; $display("FAIL tie_resp op %0d got v0=%b v1=%b r=%0d", i, rsp0_valid, rsp1_valid, rsp_result);
            end
            step();
            lastg_m = g; count_m = model_sat(count_m);
        end
        idle_inputs();
        #1;
        checks++;
        if (op_count !== 3'd4) begin errors++; $display("FAIL tie_count got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        exp = model_result(32'hDEAD_0000, 32'h0000_BEEF, 3'b011);
        req1_valid = 1; req1_a = 32'hDEAD_0000; req1_b = 32'h0000_BEEF; req1_op = 3'b011;
        step();
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 3'b001;
        rsp0_ready = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== exp || req0_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got v1=%b v0=%b r=%h rdy0=%b want 1 0 %h 0",
                    i, rsp1_valid, rsp0_valid, rsp_result, req0_ready, exp);
            end
            step();
        end
        rsp1_ready = 1;
        #1;
        step();
        rsp1_ready = 0;
        lastg_m = 1; count_m = model_sat(count_m);
        checks++;
        if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy0=%b v1=%b want 1 0", req0_ready, rsp1_valid);
        end
        step();
        req0_valid = 0;
        step();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_result !== 32'd99) begin
            errors++; $display("FAIL bp_next got v0=%b r=%0d want 1 99", rsp0_valid, rsp_result);
        end
        step();
        rsp0_ready = 0;
        lastg_m = 0; count_m = model_sat(count_m);
    endtask

    task automatic test_bad_op();
        logic rdy, ev, rv, er; logic [31:0] res;
        do_op(1, 32'd7, 32'd9, 3'b110, rdy, ev, rv, res, er);
        checks++;
        if (rv !== 1'b1 || res !== 32'd0 || er !== 1'b1) begin
            errors++; $display("FAIL bad_op got v=%b r=%0d e=%b want 1 0 1", rv, res, er);
        end
        checks++;
        if (op_count !== 3'(count_m)) begin
            errors++; $display("FAIL bad_op_count got %0d want %0d", op_count, count_m);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        req1_valid = 1; req1_a = 32'd40; req1_b = 32'd2; req1_op = 0;
        step();
        req1_valid = 0;
        rst = 0;
        req0_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            errors++; $display("FAIL rstmid_low got %b want 00000",
                {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        step();
        rst = 1; req0_valid = 0;
        lastg_m = 1; count_m = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp0_valid || rsp1_valid || busy) seen = 1;
            step();
        end
        checks++;
        if (seen !== 1'b0 || op_count !== 3'd0) begin
            errors++; $display("FAIL rstmid_discard got seen=%b count=%0d want 0 0", seen, op_count);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_tie got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        step();
        idle_inputs();
        rsp0_ready = 1;
        step(); step();
        rsp0_ready = 0;
        lastg_m = 0; count_m = model_sat(count_m);
    endtask

    task automatic test_random();
        logic v0, v1, g, r_own, r_oth;
        logic [31:0] a0, b0, a1, b1, exp; logic [2:0] o0, o1; logic experr;
        int k;
        for (int n = 0; n < 40; n++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            a0 = $urandom; b0 = $urandom; o0 = 3'($urandom_range(0, 7));
            a1 = $urandom; b1 = $urandom; o1 = 3'($urandom_range(0, 7));
            req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
            req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
            g = (v0 && v1) ? !lastg_m : v1;
            #1;
            checks++;
            if (req0_ready !== (v0 && !g) || req1_ready !== (v1 && g)) begin
                errors++; $display("FAIL rand_grant n %0d got r0=%b r1=%b v=%b%b", n, req0_ready, req1_ready, v0, v1);
            end
            if (!v0 && !v1) begin step(); continue; end
            exp    = g ? model_result(a1, b1, o1) : model_result(a0, b0, o0);
            experr = g ? (o1 > 3'd4) : (o0 > 3'd4);
            step();
            req0_valid = 0; req1_valid = 0;
            step();
            k = $urandom_range(0, 3);
            for (int c = 0; c <= k; c++) begin
                r_own = (c == k); r_oth = 1'($urandom_range(0, 1));
                rsp0_ready = g ? r_oth : r_own;
                rsp1_ready = g ? r_own : r_oth;
                #1;
                checks++;
                if (rsp0_valid !== !g || rsp1_valid !== g || rsp_result !== exp || rsp_err !== experr) begin
                    errors++; $display("FAIL rand_resp n %0d got v0=%b v1=%b r=%h e=%b want g=%0d r=%h e=%b",
                        n, rsp0_valid, rsp1_valid, rsp_result, rsp_err, g, exp, experr);
                end
                step();
            end
            rsp0_ready = 0; rsp1_ready = 0;
            lastg_m = g; count_m = model_sat(count_m);
            checks++;
            if (op_count !== 3'(count_m) || busy !== 1'b0) begin
                errors++; $display("FAIL rand_count n %0d got %0d busy %b want %0d", n, op_count, busy, count_m);
            end
        end
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        lastg_m = 1; count_m = 0;
        test_reset();
        test_single();
        test_wrap_not();
        test_tie();
        test_backpressure();
        test_bad_op();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
